// File: rtl/tmr_vote_monitor.sv
// TMR merge point: registered bitwise majority vote of three copies, with
// per-copy saturating error counters, persistent-fault flags and a
// software clear handshake (clrReq level in, one-cycle clrAck out).
module tmr_vote_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16,
    parameter int PERSIST   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    output logic [WIDTH-1:0]     out,
    output logic                 tmrErr,
    output logic                 multiErr,
    output logic [CNT_WIDTH-1:0] errCntA,
    output logic [CNT_WIDTH-1:0] errCntB,
    output logic [CNT_WIDTH-1:0] errCntC,
    output logic                 failA,
    output logic                 failB,
    output logic                 failC,
    input  logic                 clrReq,
    output logic                 clrAck
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        ACK      = 2'd2,
        WAIT_LOW = 2'd3
    } clrState_t;

    // Run-length counters are 8 bits wide, so the threshold is held in 8 bits.
    localparam logic [7:0] PERSIST_L = 8'(PERSIST);

    // Error counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_WIDTH'(1);
    endfunction

    // Run length never needs to exceed the threshold, so it saturates there.
    function automatic logic [7:0] runInc(input logic [7:0] run);
        if (run >= PERSIST_L) begin
            return PERSIST_L;
        end
        return run + 8'd1;
    endfunction

    // True when this mismatch makes the run reach the threshold (9-bit compare
    // so run+1 cannot overflow when PERSIST is 255).
    function automatic logic reachesPersist(input logic [7:0] run);
        return ({1'b0, run} + 9'd1) >= {1'b0, PERSIST_L};
    endfunction

    // ---- stage p0: combinational vote and mismatch detection on the raw copies
    logic [WIDTH-1:0] vote_p0;
    logic [2:0]       mis_p0;
    logic             multi_p0;

    assign vote_p0   = (inA & inB) | (inA & inC) | (inB & inC);
    assign mis_p0[0] = (inA != vote_p0);
    assign mis_p0[1] = (inB != vote_p0);
    assign mis_p0[2] = (inC != vote_p0);
    assign multi_p0  = (inA != inB) && (inA != inC) && (inB != inC);

    // ---- stage p1: registered vote result and status, never stalled by clears
    logic [WIDTH-1:0] out_p1;
    logic             tmrErr_p1;
    logic             multiErr_p1;

    // Register the voted word and the per-sample error summary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1      <= '0;
            tmrErr_p1   <= 1'b0;
            multiErr_p1 <= 1'b0;
        end else begin
            out_p1      <= vote_p0;
            tmrErr_p1   <= |mis_p0;
            multiErr_p1 <= multi_p0;
        end
    end

    assign out      = out_p1;
    assign tmrErr   = tmrErr_p1;
    assign multiErr = multiErr_p1;

    // Clear handshake: one clear per rising request, ack after the clear cycle.
    clrState_t clrState;
    clrState_t clrStateNext;
    logic      clearNow;

    // Clear FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrState <= IDLE;
        end else begin
            clrState <= clrStateNext;
        end
    end

    // Clear FSM next-state and decoded controls.
    always_comb begin
        clrStateNext = clrState;
        clearNow     = 1'b0;
        clrAck       = 1'b0;
        case (clrState)
            IDLE: begin
                if (clrReq) begin
                    clrStateNext = CLEAR;
                end
            end
            CLEAR: begin
                clearNow     = 1'b1;
                clrStateNext = ACK;
            end
            ACK: begin
                clrAck       = 1'b1;
                clrStateNext = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!clrReq) begin
                    clrStateNext = IDLE;
                end
            end
            default: clrStateNext = IDLE;
        endcase
    end

    // ---- stage p1: per-copy error statistics (index 0=A, 1=B, 2=C)
    logic [CNT_WIDTH-1:0] errCnt_p1 [3];
    logic [7:0]           run_p1    [3];
    logic [2:0]           fail_p1;

    // Count mismatches, track consecutive runs, latch persistent faults; a
    // clear cycle discards its own sample and wins over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                errCnt_p1[i] <= '0;
                run_p1[i]    <= '0;
            end
            fail_p1 <= '0;
        end else if (clearNow) begin
            for (int i = 0; i < 3; i++) begin
                errCnt_p1[i] <= '0;
                run_p1[i]    <= '0;
            end
            fail_p1 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (mis_p0[i]) begin
                    errCnt_p1[i] <= satInc(errCnt_p1[i]);
                    run_p1[i]    <= runInc(run_p1[i]);
                    if (reachesPersist(run_p1[i])) begin
                        fail_p1[i] <= 1'b1;
                    end
                end else begin
                    run_p1[i] <= '0;
                end
            end
        end
    end

    assign errCntA = errCnt_p1[0];
    assign errCntB = errCnt_p1[1];
    assign errCntC = errCnt_p1[2];
    assign failA   = fail_p1[0];
    assign failB   = fail_p1[1];
    assign failC   = fail_p1[2];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: two instances (16-bit counters / PERSIST=4 and
// 4-bit counters / PERSIST=1) share stimulus and are checked against a
// behavioural model, a vector table and hand-written corner sequences.
module tb_tmr_vote_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inA, inB, inC;
    logic       clrReq;

    logic [7:0]  out0, out1;
    logic        tmrErr0, multiErr0, tmrErr1, multiErr1;
    logic [15:0] errCntA0, errCntB0, errCntC0;
    logic [3:0]  errCntA1, errCntB1, errCntC1;
    logic        failA0, failB0, failC0, failA1, failB1, failC1;
    logic        clrAck0, clrAck1;

    tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(16), .PERSIST(4)) dut0 (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .out(out0), .tmrErr(tmrErr0), .multiErr(multiErr0),
        .errCntA(errCntA0), .errCntB(errCntB0), .errCntC(errCntC0),
        .failA(failA0), .failB(failB0), .failC(failC0),
        .clrReq(clrReq), .clrAck(clrAck0)
    );

    tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(4), .PERSIST(1)) dut1 (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .out(out1), .tmrErr(tmrErr1), .multiErr(multiErr1),
        .errCntA(errCntA1), .errCntB(errCntB1), .errCntC(errCntC1),
        .failA(failA1), .failB(failB1), .failC(failC1),
        .clrReq(clrReq), .clrAck(clrAck1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: unbounded mismatch totals and consecutive-run lengths,
    // clipped or thresholded only when compared.
    int         mCnt  [2][3];
    int         mRun  [2][3];
    bit         mFail [2][3];
    int         mPhase;   // 0 idle, 1 clearing, 2 acknowledging, 3 waiting for release
    logic [7:0] mOut;
    bit         mTmr, mMulti;

    function automatic int cntMax(int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic int persist(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int expCnt(int d, int x);
        return (mCnt[d][x] > cntMax(d)) ? cntMax(d) : mCnt[d][x];
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int x = 0; x < 3; x++) begin
                mCnt[d][x]  = 0;
                mRun[d][x]  = 0;
                mFail[d][x] = 1'b0;
            end
        end
        mPhase = 0;
        mOut   = 8'h00;
        mTmr   = 1'b0;
        mMulti = 1'b0;
    endtask

    // Advance the model by one sampled clock edge.
    task automatic modelEdge();
        logic [7:0] v;
        logic [7:0] cp [3];
        bit         m [3];
        cp[0] = inA; cp[1] = inB; cp[2] = inC;
        for (int k = 0; k < 8; k++) begin
            int ones;
            ones = int'(inA[k]) + int'(inB[k]) + int'(inC[k]);
            v[k] = (ones >= 2);
        end
        for (int x = 0; x < 3; x++) m[x] = (cp[x] != v);
        mOut   = v;
        mTmr   = m[0] || m[1] || m[2];
        mMulti = (inA != inB) && (inA != inC) && (inB != inC);
        for (int d = 0; d < 2; d++) begin
            for (int x = 0; x < 3; x++) begin
                if (mPhase == 1) begin
                    mCnt[d][x] = 0; mRun[d][x] = 0; mFail[d][x] = 1'b0;
                end else if (m[x]) begin
                    mCnt[d][x]++;
                    mRun[d][x]++;
                    if (mRun[d][x] >= persist(d)) mFail[d][x] = 1'b1;
                end else begin
                    mRun[d][x] = 0;
                end
            end
        end
        case (mPhase)
            0: if (clrReq) mPhase = 1;
            1: mPhase = 2;
            2: mPhase = 3;
            default: if (!clrReq) mPhase = 0;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, " out0"},      32'(out0),      32'(mOut));
        check({tag, " tmrErr0"},   32'(tmrErr0),   32'(mTmr));
        check({tag, " multiErr0"}, 32'(multiErr0), 32'(mMulti));
        check({tag, " clrAck0"},   32'(clrAck0),   32'(mPhase == 2));
        check({tag, " errCntA0"},  32'(errCntA0),  32'(expCnt(0, 0)));
        check({tag, " errCntB0"},  32'(errCntB0),  32'(expCnt(0, 1)));
        check({tag, " errCntC0"},  32'(errCntC0),  32'(expCnt(0, 2)));
        check({tag, " failA0"},    32'(failA0),    32'(mFail[0][0]));
        check({tag, " failB0"},    32'(failB0),    32'(mFail[0][1]));
        check({tag, " failC0"},    32'(failC0),    32'(mFail[0][2]));
        check({tag, " out1"},      32'(out1),      32'(mOut));
        check({tag, " tmrErr1"},   32'(tmrErr1),   32'(mTmr));
        check({tag, " multiErr1"}, 32'(multiErr1), 32'(mMulti));
        check({tag, " clrAck1"},   32'(clrAck1),   32'(mPhase == 2));
        check({tag, " errCntA1"},  32'(errCntA1),  32'(expCnt(1, 0)));
        check({tag, " errCntB1"},  32'(errCntB1),  32'(expCnt(1, 1)));
        check({tag, " errCntC1"},  32'(errCntC1),  32'(expCnt(1, 2)));
        check({tag, " failA1"},    32'(failA1),    32'(mFail[1][0]));
        check({tag, " failB1"},    32'(failB1),    32'(mFail[1][1]));
        check({tag, " failC1"},    32'(failC1),    32'(mFail[1][2]));
    endtask

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) modelReset();
        else     modelEdge();
        #1;
    endtask

    task automatic setIn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        inA = a; inB = b; inC = c;
    endtask

    // Asynchronous reset pulse starting between edges.
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("rstAsync");
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a, b, c;
        logic [7:0] expOut;
        logic       expTmr;
        logic       expMulti;
    } vec_t;

    vec_t tbl [8];
    int   ackSeen;
    int   burst;

    initial begin
        tbl[0] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 8'h3C, 8'h3D, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 8'h02, 8'h04, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'hF0, 8'h0F, 8'hFF, 8'hFF, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 8'hAA, 8'hAA, 1'b1, 1'b0};
        tbl[7] = '{8'h12, 8'h34, 8'h34, 8'h34, 1'b1, 1'b0};

        rst = 1'b1; clrReq = 1'b0; setIn(8'h00, 8'h00, 8'h00);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1'b0;

        // Vector table: vote/status against fixed values, statistics against model.
        for (int i = 0; i < 8; i++) begin
            setIn(tbl[i].a, tbl[i].b, tbl[i].c);
            step();
            check($sformatf("tbl%0d out", i),      32'(out0),      32'(tbl[i].expOut));
            check($sformatf("tbl%0d tmrErr", i),   32'(tmrErr0),   32'(tbl[i].expTmr));
            check($sformatf("tbl%0d multiErr", i), 32'(multiErr0), 32'(tbl[i].expMulti));
            checkAll($sformatf("tbl%0d", i));
        end

        // Reset with nonzero counters, then a clean sample after release.
        doReset();
        setIn(8'h5A, 8'h5A, 8'h5A);
        step();
        check("postRst out", 32'(out0), 32'h5A);
        check("postRst tmrErr", 32'(tmrErr0), 32'h0);
        check("postRst errCntA", 32'(errCntA0), 32'h0);

        // Single upset on copy C.
        setIn(8'h3C, 8'h3C, 8'h3D);
        step();
        check("upset out", 32'(out0), 32'h3C);
        check("upset tmrErr", 32'(tmrErr0), 32'h1);
        check("upset errCntC", 32'(errCntC0), 32'h1);
        check("upset failC", 32'(failC0), 32'h0);
        check("upset errCntA", 32'(errCntA0), 32'h0);
        check("upset errCntB", 32'(errCntB0), 32'h0);
        check("upset failC persist1", 32'(failC1), 32'h1);
        checkAll("upset");

        // Copy B wrong for four consecutive samples.
        doReset();
        setIn(8'h00, 8'h01, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("persist%0d failB", i), 32'(failB0), 32'(i == 4));
            checkAll($sformatf("persist%0d", i));
        end
        check("persist errCntB", 32'(errCntB0), 32'h4);

        // Two 3-cycle bursts separated by one clean cycle must not latch failB.
        doReset();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) setIn(8'h00, 8'h00, 8'h00);
            else        setIn(8'h00, 8'h01, 8'h00);
            step();
            checkAll($sformatf("burst%0d", i));
        end
        check("burst failB", 32'(failB0), 32'h0);
        check("burst errCntB", 32'(errCntB0), 32'h6);

        // Copy A wrong for 20 samples: the 4-bit counter must stop at F.
        doReset();
        setIn(8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step();
            checkAll($sformatf("sat%0d", i));
        end
        check("sat errCntA 4bit", 32'(errCntA1), 32'hF);
        check("sat errCntA 16bit", 32'(errCntA0), 32'd20);

        // Clear handshake with clrReq held 10 cycles while C keeps mismatching.
        doReset();
        setIn(8'h00, 8'h00, 8'h80);
        repeat (5) step();
        clrReq = 1'b1;
        ackSeen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (clrAck0) ackSeen++;
            checkAll($sformatf("clr%0d", i));
            if (i == 0) begin
                check("clr edge0 ack", 32'(clrAck0), 32'h0);
                check("clr edge0 errCntC", 32'(errCntC0), 32'd6);
            end
            if (i == 1) begin
                check("clr edge1 ack", 32'(clrAck0), 32'h1);
                check("clr edge1 errCntC", 32'(errCntC0), 32'h0);
                check("clr edge1 failC", 32'(failC0), 32'h0);
            end
            if (i == 2) begin
                check("clr edge2 ack", 32'(clrAck0), 32'h0);
                check("clr edge2 errCntC", 32'(errCntC0), 32'h1);
            end
        end
        clrReq = 1'b0;
        repeat (3) begin
            step();
            if (clrAck0) ackSeen++;
            checkAll("clrRelease");
        end
        check("clr ack count", 32'(ackSeen), 32'h1);

        // Reset while in CLEAR: no acknowledge may follow.
        doReset();
        setIn(8'h00, 8'h00, 8'h80);
        repeat (3) step();
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("rstInClear");
        ackSeen = 0;
        step();
        rst = 1'b0;
        repeat (4) begin
            step();
            if (clrAck0) ackSeen++;
            checkAll("afterRstClear");
        end
        check("rstClear ack count", 32'(ackSeen), 32'h0);

        // clrReq still high when reset releases starts a fresh clear.
        clrReq = 1'b1;
        doReset();
        step();
        step();
        check("reqThroughRst ack", 32'(clrAck0), 32'h1);
        checkAll("reqThroughRst");
        clrReq = 1'b0;

        // Randomized traffic against the model.
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] base;
            base = 8'($urandom);
            setIn(base, base, base);
            if ($urandom_range(3) == 0) inA = base ^ 8'($urandom_range(1, 255));
            if ($urandom_range(5) == 0) inC = base ^ 8'($urandom_range(1, 255));
            if (burst > 0) begin
                inB = base ^ 8'h10;
                burst--;
            end else if ($urandom_range(15) == 0) begin
                burst = $urandom_range(1, 6);
            end
            if ($urandom_range(19) == 0) clrReq = ~clrReq;
            step();
            checkAll($sformatf("rnd%0d", i));
        end
        clrReq = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
